// File: rtl/forwarding_hazard_unit_if.sv
// Pipeline-side bundle of the forwarding/hazard unit: the ID-stage instruction
// fields and pipeline controls in, and the EX operand selects and stall status out.
interface forwarding_hazard_unit_if #(
    parameter int REG_ADDR_WIDTH = 5,
    parameter int SEL_WIDTH      = 2,
    parameter int CNT_WIDTH      = 16
);
    logic                      id_valid;
    logic [REG_ADDR_WIDTH-1:0] id_rs;
    logic [REG_ADDR_WIDTH-1:0] id_rt;
    logic [REG_ADDR_WIDTH-1:0] id_rd;
    logic                      id_reg_write;
    logic                      id_mem_read;
    logic                      ex_flush;
    logic                      pipe_hold;
    logic [SEL_WIDTH-1:0]      forward_a;
    logic [SEL_WIDTH-1:0]      forward_b;
    logic                      stall_id;
    logic [CNT_WIDTH-1:0]      stall_count;

    modport master (
        output id_valid, id_rs, id_rt, id_rd, id_reg_write, id_mem_read,
        output ex_flush, pipe_hold,
        input  forward_a, forward_b, stall_id, stall_count
    );

    modport slave (
        input  id_valid, id_rs, id_rt, id_rd, id_reg_write, id_mem_read,
        input  ex_flush, pipe_hold,
        output forward_a, forward_b, stall_id, stall_count
    );
endinterface

// File: rtl/forwarding_hazard_unit.sv
// Operand forwarding and load-use stall detection, driven from a private shadow
// pipeline of ID-stage fields (slot 0 = EX consumer, slots 1..N = producers).
module forwarding_hazard_unit #(
    parameter int REG_ADDR_WIDTH = 5,
    parameter int NUM_FWD_STAGES = 2,
    parameter int LOAD_LATENCY   = 1,
    parameter int SEL_WIDTH      = $clog2(NUM_FWD_STAGES + 1),
    parameter int CNT_WIDTH      = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    forwarding_hazard_unit_if.slave  bus
);
    localparam int N = NUM_FWD_STAGES;

    if (NUM_FWD_STAGES < LOAD_LATENCY + 1) begin : g_bad_cfg
        $error("forwarding_hazard_unit: NUM_FWD_STAGES must be >= LOAD_LATENCY+1");
    end

    logic [N:0]                valid_reg;
    logic [N:0]                reg_write_reg;
    logic [N:0]                mem_read_reg;
    logic [REG_ADDR_WIDTH-1:0] rs_reg [0:N];
    logic [REG_ADDR_WIDTH-1:0] rt_reg [0:N];
    logic [REG_ADDR_WIDTH-1:0] rd_reg [0:N];
    logic [CNT_WIDTH-1:0]      stall_count_reg;

    logic                      stall;
    logic                      hazard;
    logic                      slot0_valid_next;
    logic [N:1]                prod_ok;
    logic [N:1]                hit_a;
    logic [N:1]                hit_b;
    logic [LOAD_LATENCY:0]     haz_vec;
    logic [SEL_WIDTH-1:0]      fwd_a_next;
    logic [SEL_WIDTH-1:0]      fwd_b_next;

    // A stalled or flushed ID instruction enters EX as a bubble.
    assign slot0_valid_next = bus.id_valid & ~stall & ~bus.ex_flush;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_reg[0]     <= 1'b0;
            reg_write_reg[0] <= 1'b0;
            mem_read_reg[0]  <= 1'b0;
            rs_reg[0]        <= '0;
            rt_reg[0]        <= '0;
            rd_reg[0]        <= '0;
        end else if (!bus.pipe_hold) begin
            valid_reg[0]     <= slot0_valid_next;
            reg_write_reg[0] <= bus.id_reg_write;
            mem_read_reg[0]  <= bus.id_mem_read;
            rs_reg[0]        <= bus.id_rs;
            rt_reg[0]        <= bus.id_rt;
            rd_reg[0]        <= bus.id_rd;
        end
    end

    for (genvar gi = 1; gi <= N; gi++) begin : g_slot
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                valid_reg[gi]     <= 1'b0;
                reg_write_reg[gi] <= 1'b0;
                mem_read_reg[gi]  <= 1'b0;
                rs_reg[gi]        <= '0;
                rt_reg[gi]        <= '0;
                rd_reg[gi]        <= '0;
            end else if (!bus.pipe_hold) begin
                valid_reg[gi]     <= valid_reg[gi-1];
                reg_write_reg[gi] <= reg_write_reg[gi-1];
                mem_read_reg[gi]  <= mem_read_reg[gi-1];
                rs_reg[gi]        <= rs_reg[gi-1];
                rt_reg[gi]        <= rt_reg[gi-1];
                rd_reg[gi]        <= rd_reg[gi-1];
            end
        end

        // Load results only become forwardable once they are LOAD_LATENCY slots past EX.
        localparam bit LOAD_READY = (gi >= LOAD_LATENCY + 1);

        assign prod_ok[gi] = valid_reg[gi] & reg_write_reg[gi] & (rd_reg[gi] != '0)
                           & (~mem_read_reg[gi] | LOAD_READY);
        assign hit_a[gi]   = valid_reg[0] & prod_ok[gi] & (rd_reg[gi] == rs_reg[0]);
        assign hit_b[gi]   = valid_reg[0] & prod_ok[gi] & (rd_reg[gi] == rt_reg[0]);
    end

    // Scan from the farthest slot inward so the nearest matching producer wins.
    always_comb begin
        fwd_a_next = '0;
        fwd_b_next = '0;
        for (int k = N; k >= 1; k--) begin
            if (hit_a[k]) fwd_a_next = SEL_WIDTH'(k);
            if (hit_b[k]) fwd_b_next = SEL_WIDTH'(k);
        end
    end

    assign haz_vec[LOAD_LATENCY] = 1'b0;
    for (genvar gi = 0; gi < LOAD_LATENCY; gi++) begin : g_haz
        assign haz_vec[gi] = valid_reg[gi] & mem_read_reg[gi] & reg_write_reg[gi]
                           & (rd_reg[gi] != '0)
                           & ((rd_reg[gi] == bus.id_rs) | (rd_reg[gi] == bus.id_rt));
    end

    assign hazard = |haz_vec;
    assign stall  = hazard & bus.id_valid & ~bus.ex_flush;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_count_reg <= '0;
        end else if (stall && !bus.pipe_hold && (stall_count_reg != '1)) begin
            stall_count_reg <= stall_count_reg + 1'b1;
        end
    end

    assign bus.forward_a   = fwd_a_next;
    assign bus.forward_b   = fwd_b_next;
    assign bus.stall_id    = stall;
    assign bus.stall_count = stall_count_reg;
endmodule

// File: tb/tb_forwarding_hazard_unit.sv
// Directed vector bench: unit 0 uses default parameters, unit 1 uses
// NUM_FWD_STAGES=3, LOAD_LATENCY=2 and a 2-bit counter to reach saturation.
module tb_forwarding_hazard_unit;
    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fail;

    forwarding_hazard_unit_if #(.REG_ADDR_WIDTH(5), .SEL_WIDTH(2), .CNT_WIDTH(16)) if0 ();
    forwarding_hazard_unit_if #(.REG_ADDR_WIDTH(5), .SEL_WIDTH(2), .CNT_WIDTH(2))  if1 ();

    forwarding_hazard_unit dut0 (.clk(clk), .rst_n(rst_n), .bus(if0));

    forwarding_hazard_unit #(
        .REG_ADDR_WIDTH(5), .NUM_FWD_STAGES(3), .LOAD_LATENCY(2), .SEL_WIDTH(2), .CNT_WIDTH(2)
    ) dut1 (.clk(clk), .rst_n(rst_n), .bus(if1));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        unit;
        logic        v;
        logic [4:0]  rs, rt, rd;
        logic        rw, mr, fl, hd;
        logic [1:0]  fa, fb;
        logic        st;
        logic [15:0] cnt;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic unit, v, input logic [4:0] rs, rt, rd,
                                input logic rw, mr, fl, hd, input logic [1:0] fa, fb,
                                input logic st, input logic [15:0] cnt);
        vec_t t;
        t.unit = unit; t.v = v; t.rs = rs; t.rt = rt; t.rd = rd;
        t.rw = rw; t.mr = mr; t.fl = fl; t.hd = hd;
        t.fa = fa; t.fb = fb; t.st = st; t.cnt = cnt;
        return t;
    endfunction

    task automatic check(input string name, input int idx, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s [%0d]: got %0d expected %0d", name, idx, act, exp);
        end
    endtask

    task automatic idle(input logic unit);
        if (unit) begin
            if1.id_valid = 0; if1.id_rs = 0; if1.id_rt = 0; if1.id_rd = 0;
            if1.id_reg_write = 0; if1.id_mem_read = 0; if1.ex_flush = 0; if1.pipe_hold = 0;
        end else begin
            if0.id_valid = 0; if0.id_rs = 0; if0.id_rt = 0; if0.id_rd = 0;
            if0.id_reg_write = 0; if0.id_mem_read = 0; if0.ex_flush = 0; if0.pipe_hold = 0;
        end
    endtask

    task automatic randomize_inputs();
        if0.id_valid = 1'($urandom); if0.id_rs = 5'($urandom); if0.id_rt = 5'($urandom);
        if0.id_rd = 5'($urandom); if0.id_reg_write = 1'($urandom); if0.id_mem_read = 1'($urandom);
        if0.ex_flush = 1'($urandom); if0.pipe_hold = 1'($urandom);
        if1.id_valid = 1'($urandom); if1.id_rs = 5'($urandom); if1.id_rt = 5'($urandom);
        if1.id_rd = 5'($urandom); if1.id_reg_write = 1'($urandom); if1.id_mem_read = 1'($urandom);
        if1.ex_flush = 1'($urandom); if1.pipe_hold = 1'($urandom);
    endtask

    task automatic apply(input vec_t t);
        idle(~t.unit);
        if (t.unit) begin
            if1.id_valid = t.v; if1.id_rs = t.rs; if1.id_rt = t.rt; if1.id_rd = t.rd;
            if1.id_reg_write = t.rw; if1.id_mem_read = t.mr; if1.ex_flush = t.fl; if1.pipe_hold = t.hd;
        end else begin
            if0.id_valid = t.v; if0.id_rs = t.rs; if0.id_rt = t.rt; if0.id_rd = t.rd;
            if0.id_reg_write = t.rw; if0.id_mem_read = t.mr; if0.ex_flush = t.fl; if0.pipe_hold = t.hd;
        end
    endtask

    task automatic check_all(input string tag, input int idx, input logic unit,
                             input int fa, input int fb, input int st, input int cnt);
        if (unit) begin
            check({tag, "_fwd_a"}, idx, int'(if1.forward_a), fa);
            check({tag, "_fwd_b"}, idx, int'(if1.forward_b), fb);
            check({tag, "_stall"}, idx, int'(if1.stall_id), st);
            check({tag, "_count"}, idx, int'(if1.stall_count), cnt);
        end else begin
            check({tag, "_fwd_a"}, idx, int'(if0.forward_a), fa);
            check({tag, "_fwd_b"}, idx, int'(if0.forward_b), fb);
            check({tag, "_stall"}, idx, int'(if0.stall_id), st);
            check({tag, "_count"}, idx, int'(if0.stall_count), cnt);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        n_checks = 0;
        n_fail   = 0;

        // unit 0, defaults: ALU chain, double hit, rd=0, load-use, hold, flush
        vecs.push_back(mk(0, 1, 2, 3, 1, 1, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 1, 1, 1, 4, 1, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 1, 1, 5, 6, 1, 0, 0, 0, 1, 1, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 2, 0, 0, 0));
        vecs.push_back(mk(0, 1, 0, 0, 10, 1, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 1, 0, 0, 10, 1, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 1, 10, 7, 8, 1, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0));
        vecs.push_back(mk(0, 1, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 1, 0, 0, 9, 1, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 1, 0, 0, 3, 1, 1, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 1, 3, 4, 5, 1, 0, 0, 0, 0, 0, 1, 0));
        vecs.push_back(mk(0, 1, 3, 4, 5, 1, 0, 0, 0, 0, 0, 0, 1));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 2, 0, 0, 1));
        vecs.push_back(mk(0, 1, 0, 0, 7, 1, 1, 0, 0, 0, 0, 0, 1));
        vecs.push_back(mk(0, 1, 2, 7, 8, 1, 0, 0, 1, 0, 0, 1, 1));
        vecs.push_back(mk(0, 1, 2, 7, 8, 1, 0, 0, 1, 0, 0, 1, 1));
        vecs.push_back(mk(0, 1, 2, 7, 8, 1, 0, 0, 1, 0, 0, 1, 1));
        vecs.push_back(mk(0, 1, 2, 7, 8, 1, 0, 0, 0, 0, 0, 1, 1));
        vecs.push_back(mk(0, 1, 2, 7, 8, 1, 0, 0, 0, 0, 0, 0, 2));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2, 0, 2));
        vecs.push_back(mk(0, 1, 0, 0, 9, 1, 1, 0, 0, 0, 0, 0, 2));
        vecs.push_back(mk(0, 1, 9, 0, 12, 1, 0, 1, 0, 0, 0, 0, 2));
        vecs.push_back(mk(0, 1, 12, 9, 1, 1, 0, 0, 0, 0, 0, 0, 2));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2, 0, 2));
        // unit 1: two-cycle load-use, forward from slot 3, counter saturation
        vecs.push_back(mk(1, 1, 0, 0, 3, 1, 1, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(1, 1, 5, 3, 6, 1, 0, 0, 0, 0, 0, 1, 0));
        vecs.push_back(mk(1, 1, 5, 3, 6, 1, 0, 0, 0, 0, 0, 1, 1));
        vecs.push_back(mk(1, 1, 5, 3, 6, 1, 0, 0, 0, 0, 0, 0, 2));
        vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 3, 0, 2));
        vecs.push_back(mk(1, 1, 0, 0, 3, 1, 1, 0, 0, 0, 0, 0, 2));
        vecs.push_back(mk(1, 1, 3, 0, 6, 1, 0, 0, 0, 0, 0, 1, 2));
        vecs.push_back(mk(1, 1, 3, 0, 6, 1, 0, 0, 0, 0, 0, 1, 3));
        vecs.push_back(mk(1, 1, 3, 0, 6, 1, 0, 0, 0, 0, 0, 0, 3));
        vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 3, 0, 0, 3));

        // reset with random inputs, then the first cycle after release
        rst_n = 1'b0;
        randomize_inputs();
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            randomize_inputs();
            #1;
            check_all("rst_u0", c, 1'b0, 0, 0, 0, 0);
            check_all("rst_u1", c, 1'b1, 0, 0, 0, 0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        randomize_inputs();
        #1;
        check_all("post_rst_u0", 0, 1'b0, 0, 0, 0, 0);
        check_all("post_rst_u1", 0, 1'b1, 0, 0, 0, 0);
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            idle(1'b0);
            idle(1'b1);
        end

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            apply(vecs[i]);
            #1;
            $display("vec %0d unit %0d: fa=%0d fb=%0d stall=%0d cnt=%0d", i, vecs[i].unit,
                     vecs[i].unit ? if1.forward_a : if0.forward_a,
                     vecs[i].unit ? if1.forward_b : if0.forward_b,
                     vecs[i].unit ? if1.stall_id : if0.stall_id,
                     vecs[i].unit ? 16'(if1.stall_count) : if0.stall_count);
            check_all("vec", i, vecs[i].unit, int'(vecs[i].fa), int'(vecs[i].fb),
                      int'(vecs[i].st), int'(vecs[i].cnt));
        end

        // asynchronous reset in the middle of a load-use stall on unit 0
        @(negedge clk);
        apply(mk(0, 1, 0, 0, 3, 1, 1, 0, 0, 0, 0, 0, 0));
        @(negedge clk);
        apply(mk(0, 1, 3, 0, 4, 1, 0, 0, 0, 0, 0, 0, 0));
        #1;
        check("midrst_pre_stall", 0, int'(if0.stall_id), 1);
        #2;
        rst_n = 1'b0;
        #1;
        check_all("midrst_u0", 0, 1'b0, 0, 0, 0, 0);
        check("midrst_u1_count", 0, int'(if1.stall_count), 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check_all("midrst_release_u0", 0, 1'b0, 0, 0, 0, 0);
        @(negedge clk);
        #1;
        check("midrst_restart_count", 0, int'(if0.stall_count), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
